// File: rtl/counter_bank_pipe.sv
// counter_bank_pipe
//   Bank of 2**ADDR_W saturating up/down event counters. Each event passes
//   through a two-stage read-modify-write pipeline. Stage 1 latches the
//   address and direction and reads the counter. Stage 2 writes the new value
//   back. A back-to-back event to the same address takes the value that
//   stage 2 is writing instead of the stale bank entry. A clear-all sweep
//   first drains the pipeline and then zeroes one counter per cycle. A
//   running total tracks the sum of all counters.
//
//   Optional feature, enabled by defining COUNTER_BANK_SAT_FLAG_EN: each
//   counter gets a sticky saturation flag, which is set whenever an event is
//   dropped because the counter is already saturated. Two extra outputs are
//   added: sat_any and sat_rd.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   evt_valid  event request
//   evt_ready  event can be accepted (low while the clear sweep runs)
//   evt_addr   counter to update
//   evt_down   0 = increment, 1 = decrement
//   clr_all    single-cycle pulse that starts the clear sweep
//   busy       clear sweep (drain + sweep) in progress
//   rd_addr    readout address
//   rd_data    registered committed value of bank[rd_addr]
//   total      sum of all counters
//   sat_any    (optional) OR of all saturation flags
//   sat_rd     (optional) saturation flag of rd_addr, aligned with rd_data
module counter_bank_pipe #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8,
  parameter int TOT_W  = CNT_W + ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              evt_valid,
  output logic              evt_ready,
  input  logic [ADDR_W-1:0] evt_addr,
  input  logic              evt_down,
  input  logic              clr_all,
  output logic              busy,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  rd_data,
  output logic [TOT_W-1:0]  total
`ifdef COUNTER_BANK_SAT_FLAG_EN
  ,
  output logic              sat_any,
  output logic              sat_rd
`endif
);

  localparam int NCNT = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CMAX = '1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] SWEEP = 2'd2;

  function automatic logic is_sat(input logic [CNT_W-1:0] v, input logic down);
    return down ? (v == '0) : (v == CMAX);
  endfunction

  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] v,
                                                input logic down);
    if (is_sat(v, down)) return v;
    return down ? v - CNT_W'(1) : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0]  bank [NCNT];
  logic [1:0]        state;
  logic [ADDR_W-1:0] idx;

  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic              down_p1;
  logic [CNT_W-1:0]  val_p1;

  logic              accept;
  logic              sat_p1;
  logic [CNT_W-1:0]  new_p1;
  logic              fwd;
  logic              drained;

  assign busy      = (state != IDLE);
  assign evt_ready = !busy;
  assign accept    = evt_valid && evt_ready;
  assign sat_p1    = is_sat(val_p1, down_p1);
  assign new_p1    = sat_step(val_p1, down_p1);
  // Stage 2 is writing the address that stage 1 is reading on this edge.
  assign fwd       = vld_p1 && (addr_p1 == evt_addr);
  assign drained   = (state == DRAIN) && !vld_p1;

  // Clear-sweep control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: if (clr_all) state <= DRAIN;
        DRAIN: begin
          if (!vld_p1) begin
            state <= SWEEP;
            idx   <= '0;
          end
        end
        SWEEP: begin
          idx <= idx + ADDR_W'(1);
          if (&idx) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1: latch the event and read its counter (forwarded if needed)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1 <= evt_addr;
      down_p1 <= evt_down;
      val_p1  <= fwd ? new_p1 : bank[evt_addr];
    end
  end

  // Stage 2: commit the new value, or sweep one entry to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCNT; i++) bank[i] <= '0;
    end else if (state == SWEEP) begin
      bank[idx] <= '0;
    end else if (vld_p1) begin
      bank[addr_p1] <= new_p1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  total <= '0;
    else if (drained)         total <= '0;
    else if (vld_p1 && !sat_p1)
      total <= down_p1 ? total - TOT_W'(1) : total + TOT_W'(1);
  end

  // Read port: committed contents only, one cycle latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= bank[rd_addr];
  end

`ifdef COUNTER_BANK_SAT_FLAG_EN
  logic [NCNT-1:0] sat_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    sat_flag <= '0;
    else if (state == SWEEP)    sat_flag[idx] <= 1'b0;
    else if (vld_p1 && sat_p1)  sat_flag[addr_p1] <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_rd <= 1'b0;
    else     sat_rd <= sat_flag[rd_addr];
  end

  assign sat_any = |sat_flag;
`endif

endmodule

// File: doc/counter_bank_pipe.md
Name: counter_bank_pipe

Overview:
- Parametrised bank of 2**ADDR_W saturating event counters.
- Successor to the async-strobe vote/count bank: fully synchronous, up/down increments, ready/valid event input, 2-stage read-modify-write pipeline with forwarding, runtime clear-all sweep FSM, running total.
- Sits between the event decoder (e.g. the position/selection logic) and display/readout logic, which samples counters via a registered read port.

Parameters:
- ADDR_W, 4, counter address width; NCNT = 2**ADDR_W counters.
- CNT_W, 8, width of each counter; max value CMAX = 2**CNT_W-1.
- TOT_W, CNT_W+ADDR_W, width of the running-total output.

Ports:
- clk  in  1  system clock, all state changes on posedge.
- rst  in  1  reset, asynchronous, active-high.
- evt_valid  in  1  event request.
- evt_ready  out  1  high when an event can be accepted; equals !busy.
- evt_addr  in  ADDR_W  counter to update.
- evt_down  in  1  0 = increment, 1 = decrement.
- clr_all  in  1  single-cycle pulse starting the clear sweep.
- busy  out  1  clear sweep in progress.
- rd_addr  in  ADDR_W  readout address.
- rd_data  out  CNT_W  registered counter value.
- total  out  TOT_W  sum of all counters.

Behaviour:
- Reset (async): all counters 0, total 0, rd_data 0, busy 0, pipeline valids 0, FSM in IDLE.
- Accept: event accepted on a posedge where evt_valid && evt_ready.
- S1 (edge N): latch addr and dir, and read the bank entry into an s1_val register.
- S2 (edge N+1): compute the new value and write it to the bank.
  - The counter value is visible on rd_data after the posedge N+2 read.
- Forwarding: if S2 writes address A on the same edge S1 reads A, s1_val takes S2's new value, not the stale bank value. Back-to-back events to the same address must never lose counts.
- Arithmetic: increment saturates at CMAX; decrement saturates at 0. A saturated event changes neither the counter nor total.
  - total += 1 on an effective increment, -= 1 on an effective decrement, applied on the S2 edge.
- Read port: rd_data <= bank[rd_addr] every posedge. It shows committed bank contents only, with no forwarding. Latency is 1 cycle.
- FSM states:
  - IDLE: clr_all moves to DRAIN.
  - DRAIN: wait until S1 and S2 are empty, then go to SWEEP with idx = 0 and total <= 0.
  - SWEEP: write bank[idx] = 0, idx++; after idx = NCNT-1 go to IDLE.
- busy is high from the edge after clr_all until the last sweep write. evt_ready = 0 during DRAIN/SWEEP. Events already in the pipeline complete before the sweep starts.
- clr_all while busy is ignored. clr_all together with evt_valid in IDLE: the event is accepted that cycle and then drained.
- Reset mid-sweep or mid-pipeline returns immediately to the reset state.
- Sweep duration: drain (≤ 2 cycles) + NCNT cycles.

Optional Feature:
- Macro: COUNTER_BANK_SAT_FLAG_EN.
- With the macro defined, the block adds:
  - a per-counter sticky saturation bit, set on any saturated (dropped) event;
  - output sat_any (1 bit, OR of all flags);
  - output sat_rd (1 bit, the flag for rd_addr, registered with rd_data).
- Flags are cleared by rst and by the clear sweep (per index, as swept).
- Without the macro, no flag storage and no sat_any/sat_rd ports exist.

Test Plan:
- Reset, then 3 increments to addr 5 on consecutive cycles, rd_addr = 5 -> rd_data = 3 four cycles after the last accept; total = 3 (checks forwarding).
- CNT_W=8: 257 increments to addr 2 -> counter 255, total 255; with SAT_FLAG_EN, sat_any = 1.
- 2 increments then 3 decrements to addr 7 -> counter 0, total 0; third decrement dropped.
- Counters at 4/9/1 on addr 0/1/2, pulse clr_all with an event to addr 3 in flight -> addr 3 becomes 1 then 0; busy high for drain + 16 cycles; evt_ready low throughout; all counters 0 and total 0 at the end.
- Assert rst mid-sweep at idx 6 -> busy 0, all outputs 0 immediately, without waiting for a clock edge.
- Alternating addresses 1,2,1,2 each cycle for 20 cycles -> counters 10 and 10, total 20.
